// File: rtl/writeback_stage.sv
// ============================================================================
// writeback_stage: selects one of NUM_SRC results or an aligned/extended load,
// waits for late memory data, drives a registered RF write and forwarding port.
// Optional retire counter: define WB_RETIRE_CNT_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module writeback_stage #(
  parameter int WIDTH      = 32,
  parameter int NUM_SRC    = 4,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 64,
  parameter int SEL_W      = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_reg_write,
  input  logic [REG_ADDR_W-1:0]    in_rd,
  input  logic                     in_is_load,
  input  logic [SEL_W-1:0]         in_wb_sel,
  input  logic [NUM_SRC*WIDTH-1:0] in_src_data,
  input  logic [2:0]               in_funct3,
  input  logic [2:0]               in_addr_lo,
  input  logic                     mem_rvalid,
  input  logic [WIDTH-1:0]         mem_rdata,
  output logic                     rf_we,
  output logic [REG_ADDR_W-1:0]    rf_waddr,
  output logic [WIDTH-1:0]         rf_wdata,
  output logic                     fwd_valid,
  output logic [REG_ADDR_W-1:0]    fwd_rd,
  output logic [WIDTH-1:0]         fwd_data,
  output logic [CNT_W-1:0]         retire_count
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [REG_ADDR_W-1:0] pend_rd_q, pend_rd_d;
  logic                  pend_we_q, pend_we_d;
  logic [2:0]            pend_f3_q, pend_f3_d;
  logic [2:0]            pend_addr_q, pend_addr_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [WIDTH-1:0]      rf_wdata_q, rf_wdata_d;

  logic                  w_accept;
  logic                  w_complete;
  logic                  w_cmp_we;
  logic [REG_ADDR_W-1:0] w_cmp_rd;
  logic [WIDTH-1:0]      w_cmp_data;
  logic [WIDTH-1:0]      w_src_data;

  // Lanes are picked by the truncated offset, so misaligned accesses never trap.
  function automatic logic [WIDTH-1:0] extract_load(
    input logic [WIDTH-1:0] raw,
    input logic [2:0]       f3,
    input logic [2:0]       a
  );
    logic [63:0] w64;
    logic [2:0]  byte_lane;
    logic [1:0]  half_lane;
    logic        word_lane;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    logic [63:0] r;
    w64       = 64'(raw);
    byte_lane = (WIDTH == 64) ? a : {1'b0, a[1:0]};
    half_lane = (WIDTH == 64) ? a[2:1] : {1'b0, a[1]};
    word_lane = (WIDTH == 64) ? a[2] : 1'b0;
    b = 8'(w64 >> {byte_lane, 3'b000});
    h = 16'(w64 >> {half_lane, 4'b0000});
    w = 32'(w64 >> {word_lane, 5'b00000});
    case (f3)
      3'b000:  r = {{56{b[7]}}, b};
      3'b001:  r = {{48{h[15]}}, h};
      3'b010:  r = {{32{w[31]}}, w};
      3'b100:  r = {56'b0, b};
      3'b101:  r = {48'b0, h};
      3'b110:  r = (WIDTH == 64) ? {32'b0, w} : {{32{w[31]}}, w};
      default: r = (WIDTH == 64) ? w64 : {{32{w[31]}}, w};
    endcase
    return WIDTH'(r);
  endfunction

  always_comb begin
    w_src_data = in_src_data[WIDTH-1:0];
    for (int k = 1; k < NUM_SRC; k++) begin
      if (in_wb_sel == SEL_W'(k)) w_src_data = in_src_data[k*WIDTH +: WIDTH];
    end
  end

  assign in_ready = (state_q == IDLE);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    pend_rd_d   = pend_rd_q;
    pend_we_d   = pend_we_q;
    pend_f3_d   = pend_f3_q;
    pend_addr_d = pend_addr_q;
    w_complete  = 1'b0;
    w_cmp_we    = 1'b0;
    w_cmp_rd    = '0;
    w_cmp_data  = '0;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          w_cmp_we = in_reg_write;
          w_cmp_rd = in_rd;
          if (!in_is_load) begin
            w_complete = 1'b1;
            w_cmp_data = w_src_data;
          end else if (mem_rvalid) begin
            w_complete = 1'b1;
            w_cmp_data = extract_load(mem_rdata, in_funct3, in_addr_lo);
          end else begin
            pend_rd_d   = in_rd;
            pend_we_d   = in_reg_write;
            pend_f3_d   = in_funct3;
            pend_addr_d = in_addr_lo;
            state_d     = WAIT_MEM;
          end
        end
      end
      default: begin
        if (mem_rvalid) begin
          w_complete = 1'b1;
          w_cmp_we   = pend_we_q;
          w_cmp_rd   = pend_rd_q;
          w_cmp_data = extract_load(mem_rdata, pend_f3_q, pend_addr_q);
          state_d    = IDLE;
        end
      end
    endcase
    rf_we_d    = w_complete && w_cmp_we && (w_cmp_rd != '0);
    rf_waddr_d = w_complete ? w_cmp_rd : rf_waddr_q;
    rf_wdata_d = w_complete ? w_cmp_data : rf_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_rd_q   <= '0;
      pend_we_q   <= 1'b0;
      pend_f3_q   <= '0;
      pend_addr_q <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_rd_q   <= pend_rd_d;
      pend_we_q   <= pend_we_d;
      pend_f3_q   <= pend_f3_d;
      pend_addr_q <= pend_addr_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign fwd_valid = rf_we_q;
  assign fwd_rd    = rf_waddr_q;
  assign fwd_data  = rf_wdata_q;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_count_q, retire_count_d;

  // Counts every completion, including rd=0 and non-writing instructions.
  always_comb begin
    retire_count_d = retire_count_q + CNT_W'(w_complete);
  end

  always_ff @(posedge clk) begin
    if (rst) retire_count_q <= '0;
    else     retire_count_q <= retire_count_d;
  end

  assign retire_count = retire_count_q;
`else
  assign retire_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ============================================================================
// tb_writeback_stage: directed self-checking bench for writeback_stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_writeback_stage;

  localparam int WIDTH      = 32;
  localparam int NUM_SRC    = 5;  // five sources so an out-of-range select is representable
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 64;
  localparam int SEL_W      = $clog2(NUM_SRC);
`ifdef WB_RETIRE_CNT_EN
  localparam int CNT_INC = 1;
`else
  localparam int CNT_INC = 0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_reg_write;
  logic [REG_ADDR_W-1:0]    in_rd;
  logic                     in_is_load;
  logic [SEL_W-1:0]         in_wb_sel;
  logic [NUM_SRC*WIDTH-1:0] in_src_data;
  logic [2:0]               in_funct3;
  logic [2:0]               in_addr_lo;
  logic                     mem_rvalid;
  logic [WIDTH-1:0]         mem_rdata;
  logic                     rf_we;
  logic [REG_ADDR_W-1:0]    rf_waddr;
  logic [WIDTH-1:0]         rf_wdata;
  logic                     fwd_valid;
  logic [REG_ADDR_W-1:0]    fwd_rd;
  logic [WIDTH-1:0]         fwd_data;
  logic [CNT_W-1:0]         retire_count;

  logic [WIDTH-1:0] src [NUM_SRC];
  logic [CNT_W-1:0] exp_cnt;
  int checks;
  int errors;

  assign in_src_data = {src[4], src[3], src[2], src[1], src[0]};

  always #5 clk = ~clk;

  writeback_stage #(
    .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_is_load(in_is_load),
    .in_wb_sel(in_wb_sel), .in_src_data(in_src_data),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retire_count(retire_count)
  );

  task automatic idle_inputs();
    in_valid     = 1'b0;
    in_reg_write = 1'b0;
    in_rd        = '0;
    in_is_load   = 1'b0;
    in_wb_sel    = '0;
    in_funct3    = '0;
    in_addr_lo   = '0;
    mem_rvalid   = 1'b0;
    mem_rdata    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < NUM_SRC; i++) src[i] = 32'hDEAD_0000 + 32'(i);
    tick();
    tick();
    exp_cnt = '0;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'h0}) begin
      errors++;
      $display("FAIL reset_rf: got we=%0b addr=%0d data=%h expected 0/0/0", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if ({fwd_valid, fwd_rd, fwd_data} !== {1'b0, 5'd0, 32'h0}) begin
      errors++;
      $display("FAIL reset_fwd: got v=%0b rd=%0d data=%h expected 0/0/0", fwd_valid, fwd_rd, fwd_data);
    end
    checks++;
    if (retire_count !== 64'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", retire_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %0b expected 1", in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 5'd5; in_is_load = 1'b0;
    in_wb_sel = 3'd0; src[0] = 32'h1234_5678;
    tick();
    exp_cnt += CNT_INC;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234_5678}) begin
      errors++;
      $display("FAIL alu_write: got we=%0b addr=%0d data=%h expected 1/5/12345678", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 5'd5, 32'h1234_5678}) begin
      errors++;
      $display("FAIL alu_fwd: got v=%0b rd=%0d data=%h expected 1/5/12345678", fwd_valid, fwd_rd, fwd_data);
    end
    idle_inputs();
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 32'h1234_5678}) begin
      errors++;
      $display("FAIL alu_pulse_end: got we=%0b addr=%0d data=%h expected 0/5/12345678", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (retire_count !== exp_cnt) begin
      errors++;
      $display("FAIL alu_count: got %0d expected %0d", retire_count, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  sels  [4] = '{3'd1, 3'd7, 3'd3, 3'd5};
    logic [4:0]  rds   [4] = '{5'd1, 5'd2, 5'd31, 5'd4};
    logic [31:0] exps  [4] = '{32'h0000_0104, 32'h0000_00AA, 32'hC5C0_FFEE, 32'h0000_00AA};
    src[0] = 32'h0000_00AA; src[1] = 32'h0000_0104; src[3] = 32'hC5C0_FFEE; src[4] = 32'h4444_4444;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_reg_write = 1'b1; in_is_load = 1'b0;
      in_wb_sel = sels[i]; in_rd = rds[i];
      tick();
      exp_cnt += CNT_INC;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, rds[i], exps[i]}) begin
        errors++;
        $display("FAIL src_sel_%0d: got we=%0b addr=%0d data=%h expected 1/%0d/%h",
                 i, rf_we, rf_waddr, rf_wdata, rds[i], exps[i]);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (rf_we !== 1'b0 || retire_count !== exp_cnt) begin
      errors++;
      $display("FAIL b2b_end: got we=%0b count=%0d expected 0/%0d", rf_we, retire_count, exp_cnt);
    end
  endtask

  task automatic test_load_same_cycle();
    logic [2:0]  f3s  [8] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b101, 3'b000, 3'b001, 3'b111};
    logic [2:0]  adrs [8] = '{3'd3, 3'd3, 3'd2, 3'd0, 3'd0, 3'd1, 3'd3, 3'd1};
    logic [31:0] exps [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h80FF_7F01,
                              32'h0000_7F01, 32'h0000_007F, 32'hFFFF_80FF, 32'h80FF_7F01};
    src[0] = 32'h5555_5555;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_reg_write = 1'b1; in_is_load = 1'b1; in_wb_sel = 3'd0;
      in_rd = 5'(6 + i); in_funct3 = f3s[i]; in_addr_lo = adrs[i];
      mem_rvalid = 1'b1; mem_rdata = 32'h80FF_7F01;
      tick();
      exp_cnt += CNT_INC;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata, in_ready} !== {1'b1, 5'(6 + i), exps[i], 1'b1}) begin
        errors++;
        $display("FAIL load_%0d: got we=%0b addr=%0d data=%h ready=%0b expected 1/%0d/%h/1",
                 i, rf_we, rf_waddr, rf_wdata, in_ready, 6 + i, exps[i]);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_stall();
    in_valid = 1'b1; in_reg_write = 1'b1; in_is_load = 1'b1; in_rd = 5'd7;
    in_funct3 = 3'b101; in_addr_lo = 3'd0; mem_rvalid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || rf_we !== 1'b0) begin
        errors++;
        $display("FAIL stall_wait_%0d: got ready=%0b we=%0b expected 0/0", i, in_ready, rf_we);
      end
      // A competing non-load with different fields must be neither taken nor mixed in.
      in_valid = 1'b1; in_is_load = 1'b0; in_rd = 5'd9; in_funct3 = 3'b000; in_addr_lo = 3'd3;
      tick();
    end
    checks++;
    if (in_ready !== 1'b0 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL stall_wait_3: got ready=%0b we=%0b expected 0/0", in_ready, rf_we);
    end
    in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_F00D;
    tick();
    exp_cnt += CNT_INC;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, in_ready} !== {1'b1, 5'd7, 32'h0000_F00D, 1'b1}) begin
      errors++;
      $display("FAIL stall_done: got we=%0b addr=%0d data=%h ready=%0b expected 1/7/0000f00d/1",
               rf_we, rf_waddr, rf_wdata, in_ready);
    end
    idle_inputs();
    tick();
    checks++;
    if (rf_we !== 1'b0 || retire_count !== exp_cnt) begin
      errors++;
      $display("FAIL stall_end: got we=%0b count=%0d expected 0/%0d", rf_we, retire_count, exp_cnt);
    end
  endtask

  task automatic test_no_write();
    src[0] = 32'h0000_0055;
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 5'd0; in_is_load = 1'b0; in_wb_sel = 3'd0;
    tick();
    exp_cnt += CNT_INC;
    checks++;
    if ({rf_we, fwd_valid} !== 2'b00 || retire_count !== exp_cnt) begin
      errors++;
      $display("FAIL rd_zero: got we=%0b fwd=%0b count=%0d expected 0/0/%0d", rf_we, fwd_valid, retire_count, exp_cnt);
    end
    in_reg_write = 1'b0; in_rd = 5'd3;
    tick();
    exp_cnt += CNT_INC;
    checks++;
    if ({rf_we, fwd_valid} !== 2'b00 || retire_count !== exp_cnt) begin
      errors++;
      $display("FAIL no_reg_write: got we=%0b fwd=%0b count=%0d expected 0/0/%0d", rf_we, fwd_valid, retire_count, exp_cnt);
    end
    idle_inputs();
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (rf_we !== 1'b0 || retire_count !== exp_cnt) begin
      errors++;
      $display("FAIL idle_rvalid: got we=%0b count=%0d expected 0/%0d", rf_we, retire_count, exp_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_reset_wait();
    in_valid = 1'b1; in_reg_write = 1'b1; in_is_load = 1'b1; in_rd = 5'd8;
    in_funct3 = 3'b010; mem_rvalid = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_enter: got ready=%0b expected 0", in_ready);
    end
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = '0;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, in_ready} !== {1'b0, 5'd0, 32'h0, 1'b1} || retire_count !== exp_cnt) begin
      errors++;
      $display("FAIL rst_wait_clear: got we=%0b addr=%0d data=%h ready=%0b count=%0d expected 0/0/0/1/0",
               rf_we, rf_waddr, rf_wdata, in_ready, retire_count);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0012;
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, in_ready} !== {1'b0, 5'd0, 32'h0, 1'b1} || retire_count !== exp_cnt) begin
      errors++;
      $display("FAIL rst_wait_drop: got we=%0b addr=%0d data=%h ready=%0b count=%0d expected 0/0/0/1/0",
               rf_we, rf_waddr, rf_wdata, in_ready, retire_count);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = '0;
    test_reset();
    test_alu();
    test_back_to_back();
    test_load_same_cycle();
    test_stall();
    test_no_write();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
